// File: rtl/aes_sched_pkg.sv
`default_nettype none
// ============================================================================
// aes_sched_pkg : shared states, constants and xtime helper for aes_round_sched
// Revision      : 1.0
// ============================================================================
package aes_sched_pkg;

  localparam int         BLK_W     = 128;
  localparam int         AES_NR    = 10;
  localparam int         RND_W     = 4;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sched_arb.sv
`default_nettype none
// ============================================================================
// aes_sched_arb : 2-way request arbiter (round-robin when AES_SCHED_RR_EN is
//                 defined, fixed priority to requester 0 otherwise)
// Revision      : 1.0
// ============================================================================
module aes_sched_arb
  import aes_sched_pkg::*;
(
`ifdef AES_SCHED_RR_EN
  input  logic       CLK,
  input  logic       rst,
  input  logic       accept_i,
`endif
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

`ifdef AES_SCHED_RR_EN
  // prio_q set means requester 1 wins a tie; flips away from the last winner
  logic prio_q;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (accept_i) begin
      prio_q <= gnt_o[0];
    end
  end

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = prio_q ? 2'b10 : 2'b01;
    end
  end
`else
  always_comb begin
    gnt_o = req_i[0] ? 2'b01 : {req_i[1], 1'b0};
  end
`endif

endmodule
`default_nettype wire

// File: rtl/aes_round_sched.sv
`default_nettype none
// ============================================================================
// aes_round_sched : schedules AES-128 rounds through an external round engine
//                   for two requesters; AES_SCHED_RR_EN selects RR arbitration
// Revision        : 1.0
// ============================================================================
module aes_round_sched
  import aes_sched_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic [1:0]       req_valid_i,
  output logic [1:0]       req_ready_o,
  input  logic [BLK_W-1:0] req_key0_i,
  input  logic [BLK_W-1:0] req_key1_i,
  input  logic [BLK_W-1:0] req_data0_i,
  input  logic [BLK_W-1:0] req_data1_i,
  input  logic [TAG_W-1:0] req_tag0_i,
  input  logic [TAG_W-1:0] req_tag1_i,
  output logic [BLK_W-1:0] eng_din_o,
  output logic [BLK_W-1:0] eng_kin_o,
  output logic [7:0]       eng_rcon_o,
  output logic             eng_final_o,
  input  logic [BLK_W-1:0] eng_dout_i,
  input  logic [BLK_W-1:0] eng_kout_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [BLK_W-1:0] out_data_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             out_port_o,
  output logic             busy_o
);

  state_e           state_q, state_d;
  logic [BLK_W-1:0] dat_q, dat_d;
  logic [BLK_W-1:0] rkey_q, rkey_d;
  logic [7:0]       rcon_q, rcon_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             port_q, port_d;
  logic [1:0]       gnt;
  logic             accept;
  logic             in_run;

  aes_sched_arb u_arb (
`ifdef AES_SCHED_RR_EN
    .CLK      (CLK),
    .rst      (rst),
    .accept_i (accept),
`endif
    .req_i    (req_valid_i),
    .gnt_o    (gnt)
  );

  // Grant is withheld while reset is held even though state already reads IDLE
  assign req_ready_o = (state_q == IDLE && !rst) ? gnt : 2'b00;
  assign accept      = |(req_valid_i & req_ready_o);
  assign in_run      = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    dat_d   = dat_q;
    rkey_d  = rkey_q;
    rcon_d  = rcon_q;
    rnd_d   = rnd_q;
    tag_d   = tag_q;
    port_d  = port_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          port_d  = req_ready_o[1];
          dat_d   = req_ready_o[1] ? (req_data1_i ^ req_key1_i) : (req_data0_i ^ req_key0_i);
          rkey_d  = req_ready_o[1] ? req_key1_i : req_key0_i;
          tag_d   = req_ready_o[1] ? req_tag1_i : req_tag0_i;
          rcon_d  = RCON_INIT;
          rnd_d   = RND_W'(1);
        end
      end
      RUN: begin
        dat_d  = eng_dout_i;
        rkey_d = eng_kout_i;
        rcon_d = xtime(rcon_q);
        rnd_d  = rnd_q + RND_W'(1);
        if (rnd_q == RND_W'(AES_NR)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dat_q   <= '0;
      rkey_q  <= '0;
      rcon_q  <= RCON_INIT;
      rnd_q   <= '0;
      tag_q   <= '0;
      port_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      rkey_q  <= rkey_d;
      rcon_q  <= rcon_d;
      rnd_q   <= rnd_d;
      tag_q   <= tag_d;
      port_q  <= port_d;
    end
  end

  assign eng_din_o   = dat_q;
  assign eng_kin_o   = rkey_q;
  assign eng_rcon_o  = in_run ? rcon_q : 8'h00;
  assign eng_final_o = in_run && (rnd_q == RND_W'(AES_NR));
  assign out_valid_o = (state_q == DONE);
  assign out_data_o  = dat_q;
  assign out_tag_o   = tag_q;
  assign out_port_o  = port_q;
  assign busy_o      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sched.sv
`default_nettype none
// ============================================================================
// tb_aes_round_sched : AES round-engine environment, cipher reference model and
//                      directed vectors for aes_round_sched
// Revision           : 1.0
// ============================================================================
module tb_aes_round_sched;

  localparam int TAG_W = 4;
  localparam int NR    = 10;
`ifdef AES_SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             rst;
  logic [1:0]       req_valid, req_ready;
  logic [127:0]     key0, key1, data0, data1;
  logic [TAG_W-1:0] tag0, tag1;
  logic [127:0]     eng_din, eng_kin, eng_dout, eng_kout;
  logic [7:0]       eng_rcon;
  logic             eng_final;
  logic             out_valid, out_ready, out_port, busy;
  logic [127:0]     out_data;
  logic [TAG_W-1:0] out_tag;

  always #5 CLK = ~CLK;

  aes_round_sched #(.TAG_W(TAG_W)) dut (
    .CLK(CLK), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_key0_i(key0), .req_key1_i(key1),
    .req_data0_i(data0), .req_data1_i(data1),
    .req_tag0_i(tag0), .req_tag1_i(tag1),
    .eng_din_o(eng_din), .eng_kin_o(eng_kin), .eng_rcon_o(eng_rcon), .eng_final_o(eng_final),
    .eng_dout_i(eng_dout), .eng_kout_i(eng_kout),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_tag_o(out_tag), .out_port_o(out_port), .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- AES-128 arithmetic ----------------
  bit [7:0] sbox [256];
  bit [7:0] RC [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic bit [7:0] gmul(input bit [7:0] a, input bit [7:0] b);
    bit [7:0] p;
    bit [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic bit [7:0] rotl8(input bit [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      bit [7:0] inv;
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      int r, c, src;
      r   = i % 4;
      c   = i / 4;
      src = 4 * ((c + r) % 4) + r;
      o[127-8*i -: 8] = sbox[s[127-8*src -: 8]];
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      bit [7:0] a0, a1, a2, a3;
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {k[23:0], k[31:24]};
    t  = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] nk,
                                             input logic last);
    logic [127:0] t;
    t = sub_shift(s);
    if (!last) t = mix_cols(t);
    return t ^ nk;
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s, k;
    s = pt ^ key;
    k = key;
    for (int r = 0; r < NR; r++) begin
      k = key_next(k, RC[r]);
      s = aes_round(s, k, r == NR - 1);
    end
    return s;
  endfunction

  // External combinational round engine
  always @(eng_din or eng_kin or eng_rcon or eng_final) begin
    eng_kout = key_next(eng_kin, eng_rcon);
    eng_dout = aes_round(eng_din, eng_kout, eng_final);
  end

  // ---------------- reference model + per-cycle compare ----------------
  // m_age: -1 idle, 0..9 running round m_age+1, 10 result held
  int           m_age = -1;
  bit           m_prio1 = 1'b0;
  logic [127:0] m_exp, m_key, m_pt;
  logic [3:0]   m_tag;
  logic         m_port;
  int           cyc = 0;
  int           acc_port [$];
  int           acc_cyc  [$];

  always @(negedge CLK) begin : p_model
    logic [1:0] g;
    cyc++;
    if (rst) begin
      chk("rst busy", busy, 0);
      chk("rst req_ready", req_ready, 0);
      chk("rst out_valid", out_valid, 0);
      chk("rst eng_din", eng_din, 0);
      chk("rst eng_kin", eng_kin, 0);
      chk("rst eng_rcon", eng_rcon, 0);
      chk("rst out_data", out_data, 0);
      m_age   = -1;
      m_prio1 = 1'b0;
    end else begin
      g = 2'b00;
      if (m_age < 0) begin
        if (req_valid == 2'b11) g = (RR && m_prio1) ? 2'b10 : 2'b01;
        else                    g = req_valid;
      end
      chk("req_ready", req_ready, g);
      chk("busy", busy, m_age >= 0);
      chk("out_valid", out_valid, m_age == NR);
      if (m_age >= 0 && m_age < NR) begin
        chk("eng_rcon", eng_rcon, RC[m_age]);
        chk("eng_final", eng_final, m_age == NR - 1);
      end else begin
        chk("idle eng_rcon", eng_rcon, 0);
        chk("idle eng_final", eng_final, 0);
      end
      if (m_age == 0) begin
        chk("round1 eng_din", eng_din, m_pt ^ m_key);
        chk("round1 eng_kin", eng_kin, m_key);
      end
      if (m_age == NR) begin
        chk("out_data", out_data, m_exp);
        chk("out_tag", out_tag, m_tag);
        chk("out_port", out_port, m_port);
      end
      if (m_age < 0) begin
        if (g != 2'b00) begin
          m_port  = g[1];
          m_key   = m_port ? key1 : key0;
          m_pt    = m_port ? data1 : data0;
          m_tag   = m_port ? tag1 : tag0;
          m_exp   = aes_encrypt(m_key, m_pt);
          m_age   = 0;
          m_prio1 = !m_port;
          acc_port.push_back(int'(m_port));
          acc_cyc.push_back(cyc);
        end
      end else if (m_age < NR) begin
        m_age++;
      end else if (out_ready) begin
        m_age = -1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  task automatic load(input logic port, input logic [127:0] k, input logic [127:0] p,
                      input logic [3:0] t);
    if (port) begin key1 = k; data1 = p; tag1 = t; end
    else      begin key0 = k; data0 = p; tag0 = t; end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("idle timeout", busy, 0);
  endtask

  // Single request; inputs are scrambled after accept to show they are not re-sampled
  task automatic run_req(input logic port, input logic [127:0] k, input logic [127:0] p,
                         input logic [3:0] t, input logic [127:0] exp);
    @(posedge CLK); #1;
    load(port, k, p, t);
    req_valid = port ? 2'b10 : 2'b01;
    @(posedge CLK); #1;
    req_valid = 2'b00;
    chk("accepted", busy, 1);
    key0 = {4{$urandom}}; key1 = {4{$urandom}}; data0 = {4{$urandom}}; data1 = {4{$urandom}};
    tag0 = 4'(~t); tag1 = 4'(~t);
    repeat (9) @(posedge CLK);
    #1 chk("latency 9 no valid", out_valid, 0);
    @(posedge CLK); #1;
    chk("latency 10 valid", out_valid, 1);
    chk("vector out_data", out_data, exp);
    chk("vector out_tag", out_tag, t);
    chk("vector out_port", out_port, port);
  endtask

  initial begin : p_main
    int n0, n;
    build_sbox();
    rst = 1'b1;
    out_ready = 1'b1;
    req_valid = 2'b11;
    key0 = '0; key1 = '0; data0 = '0; data1 = '0; tag0 = '0; tag1 = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset req_ready held", req_ready, 0);
    chk("reset busy", busy, 0);
    req_valid = 2'b00;
    rst = 1'b0;
    repeat (2) @(posedge CLK);
    #1 chk("no request stays idle", busy, 0);

    run_req(1'b0, K1, P1, 4'd3, C1);
    run_req(1'b1, K2, P2, 4'hA, C2);

    // both requesters valid continuously for four blocks
    @(posedge CLK); #1;
    load(1'b0, K1, P1, 4'd1);
    load(1'b1, K2, P2, 4'd2);
    n0 = acc_port.size();
    req_valid = 2'b11;
    n = 0;
    while (acc_port.size() < n0 + 4 && n < 80) begin
      @(posedge CLK); #1;
      n++;
    end
    req_valid = 2'b00;
    chk("four grants seen", acc_port.size() >= n0 + 4, 1);
    if (acc_port.size() >= n0 + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("grant order", acc_port[n0+i], RR ? (i % 2) : 0);
        if (i > 0) chk("accept spacing", acc_cyc[n0+i] - acc_cyc[n0+i-1], 12);
      end
    end
    wait_idle();

    // consumer stall in DONE with both requesters pending
    out_ready = 1'b0;
    @(posedge CLK); #1;
    load(1'b0, K1, P1, 4'd9);
    req_valid = 2'b01;
    @(posedge CLK); #1;
    req_valid = 2'b11;
    repeat (10) @(posedge CLK);
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      chk("stall out_valid", out_valid, 1);
      chk("stall out_data", out_data, C1);
      chk("stall out_tag", out_tag, 9);
      chk("stall req_ready", req_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge CLK); #1;
    chk("release to idle", busy, 0);
    chk("release out_valid", out_valid, 0);
    @(posedge CLK); #1;
    chk("accept right after release", busy, 1);
    req_valid = 2'b00;
    wait_idle();

    // reset during round 5
    @(posedge CLK); #1;
    load(1'b1, K2, P2, 4'd5);
    req_valid = 2'b10;
    @(posedge CLK); #1;
    req_valid = 2'b00;
    repeat (4) @(posedge CLK);
    #1 chk("round5 rcon", eng_rcon, 8'h10);
    rst = 1'b1;
    #1;
    chk("async rst busy", busy, 0);
    chk("async rst eng_din", eng_din, 0);
    chk("async rst eng_rcon", eng_rcon, 0);
    @(posedge CLK); #1;
    rst = 1'b0;
    repeat (15) @(posedge CLK);
    #1 chk("discarded block silent", out_valid, 0);
    run_req(1'b0, K1, P1, 4'd7, C1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : p_watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/aes_round_sched.md
AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 Parameter: TAG_W, 4, width of the per-request tag returned with the result.
REQ-002 CLK  input  1  system clock, rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 req_ready  output  2  per-requester acceptance, one-hot or zero.
REQ-006 req_key0, req_key1  input  128  cipher key per requester.
REQ-007 req_data0, req_data1  input  128  plaintext per requester.
REQ-008 req_tag0, req_tag1  input  TAG_W  opaque tag per requester.
REQ-009 eng_din  output  128  state presented to the external combinational round engine.
REQ-010 eng_kin  output  128  current round key presented to the engine's key expansion.
REQ-011 eng_rcon  output  8  round constant for the key expansion.
REQ-012 eng_final  output  1  high selects final round (no MixColumns).
REQ-013 eng_dout  input  128  engine round output (state after AddRoundKey with the next key).
REQ-014 eng_kout  input  128  engine next round key.
REQ-015 out_valid  output  1  result valid; out_ready  input  1  consumer accept.
REQ-016 out_data  output  128  ciphertext; out_tag  output  TAG_W; out_port  output  1  originating requester.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, RUN, DONE; only IDLE accepts requests.
REQ-019 In IDLE, req_ready = grant one-hot for exactly one valid requester, 0 when none valid; in RUN/DONE req_ready = 0.
REQ-020 Handshake: request i accepted on rising edge where req_valid[i] & req_ready[i]; at that edge dat <= data^key, rkey <= key, rcon <= 8'h01, rnd <= 1, tag/port latched, IDLE -> RUN.
REQ-021 RUN: eng_din = dat, eng_kin = rkey, eng_rcon = rcon, eng_final = (rnd == 10); each edge dat <= eng_dout, rkey <= eng_kout, rcon <= xtime(rcon), rnd <= rnd+1.
REQ-022 rcon sequence over rounds 1..10: 01,02,04,08,10,20,40,80,1B,36; xtime = shift-left, XOR 8'h1B when bit 7 set.
REQ-023 At the edge completing round 10, RUN -> DONE; out_valid asserted exactly 10 cycles after the accept edge.
REQ-024 DONE: out_valid = 1, out_data = dat, out_tag/out_port stable until out_ready sampled high; then DONE -> IDLE, out_valid = 0 next cycle.
REQ-025 No accept on the DONE->IDLE edge; earliest next accept is the following edge (throughput 12 cycles/block with out_ready held high).
REQ-026 Outside RUN, eng_final = 0, eng_rcon = 8'h00; eng_din/eng_kin show dat/rkey.
REQ-027 Request inputs are sampled only at the accept edge; changes while RUN/DONE are ignored.
REQ-028 Requester whose req_valid drops before acceptance is simply not granted; no state change.

Reset
REQ-029 rst asserted: state IDLE, dat, rkey, out_data 0, rcon 8'h01, rnd 0, out_valid 0, busy 0, req_ready 0 while asserted, RR pointer = requester 0.
REQ-030 rst mid-RUN or mid-DONE discards the block; no out_valid is produced for it.

Configuration
REQ-031 Macro AES_SCHED_RR_EN defined: round-robin grant; requester granted last has lowest priority at next arbitration, pointer updated only on accept.
REQ-032 AES_SCHED_RR_EN undefined: fixed priority, requester 0 always wins when both valid; no pointer register.

Structure
REQ-033 Shared package aes_sched_pkg: state enum (IDLE/RUN/DONE), AES_NR = 10, RCON_INIT = 8'h01, xtime function, block/key width constant 128.
REQ-034 One sub-module aes_sched_arb (2-way arbiter, fixed or RR per REQ-031/032); FSM, counters and registers in aes_round_sched.

Verification
REQ-035 Port 0, key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, tag 3 -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_tag 3, out_port 0, out_valid 10 cycles after accept.
REQ-036 Port 1, key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32, out_port 1.
REQ-037 Both valid continuously, 4 blocks, RR enabled -> grants 0,1,0,1; RR disabled -> grants 0,0,0,0.
REQ-038 out_ready held low 20 cycles in DONE -> out_valid/out_data/out_tag stable, req_ready 0 throughout, accept one cycle after out_ready high.
REQ-039 rst pulsed at round 5 -> all outputs at reset values, no out_valid; subsequent FIPS-197 request completes correctly.
REQ-040 Monitor eng_rcon each RUN cycle -> matches REQ-022 sequence; eng_final high only in round 10.
